// File: rtl/diff_freq_serial.sv
// Serializes a latched pattern LSB-first onto one pin. Each bit lasts FAST_PERIOD or SLOW_PERIOD
// cycles, chosen by the matching freq bit. Frames are one-shot or repeat continuously.
module diff_freq_serial #(
    parameter int unsigned DATA_BIT    = 16,
    parameter int unsigned FAST_PERIOD = 4,
    parameter int unsigned SLOW_PERIOD = 10,
    parameter int unsigned CNT_BIT     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_mode,
    input  logic                i_update_tick,
    input  logic                i_start,
    input  logic                i_stop,
    output logic                o_serial_out,
    output logic                o_bit_tick,
    output logic                o_done_tick,
    output logic                o_busy
);

    localparam int unsigned        IDX_W     = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [CNT_BIT-1:0] FAST_LAST = CNT_BIT'(FAST_PERIOD - 1);
    localparam logic [CNT_BIT-1:0] SLOW_LAST = CNT_BIT'(SLOW_PERIOD - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_BIT - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [DATA_BIT-1:0] stg_pat_q, stg_pat_d;
    logic [DATA_BIT-1:0] stg_freq_q, stg_freq_d;
    logic                stg_mode_q, stg_mode_d;
    logic [DATA_BIT-1:0] work_pat_q, work_pat_d;
    logic [DATA_BIT-1:0] work_freq_q, work_freq_d;
    logic                work_mode_q, work_mode_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_BIT-1:0]  cnt_q, cnt_d;
    logic                serial_q, serial_d;
    logic                bit_tick_q, bit_tick_d;
    logic                done_tick_q, done_tick_d;
    logic                busy_q, busy_d;

    logic [DATA_BIT-1:0] ld_pat, ld_freq;
    logic                ld_mode;
    logic [CNT_BIT-1:0]  last_q, last_d;

    // An update coinciding with a load cycle must reach the working regs directly.
    assign ld_pat  = i_update_tick ? i_output_pattern : stg_pat_q;
    assign ld_freq = i_update_tick ? i_freq_pattern : stg_freq_q;
    assign ld_mode = i_update_tick ? i_mode : stg_mode_q;

    assign last_q = work_freq_q[idx_q] ? SLOW_LAST : FAST_LAST;

    always_comb begin
        state_d     = state_q;
        stg_pat_d   = stg_pat_q;
        stg_freq_d  = stg_freq_q;
        stg_mode_d  = stg_mode_q;
        work_pat_d  = work_pat_q;
        work_freq_d = work_freq_q;
        work_mode_d = work_mode_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;

        if (i_update_tick) begin
            stg_pat_d  = i_output_pattern;
            stg_freq_d = i_freq_pattern;
            stg_mode_d = i_mode;
        end

        unique case (state_q)
            StIdle: begin
                if (!i_stop && i_start) begin
                    work_pat_d  = ld_pat;
                    work_freq_d = ld_freq;
                    work_mode_d = ld_mode;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (i_stop) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == last_q) begin
                    cnt_d = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (work_mode_q) begin
                        work_pat_d  = ld_pat;
                        work_freq_d = ld_freq;
                        work_mode_d = ld_mode;
                        idx_d       = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    assign last_d = work_freq_d[idx_d] ? SLOW_LAST : FAST_LAST;

    always_comb begin
        serial_d    = 1'b0;
        bit_tick_d  = 1'b0;
        done_tick_d = 1'b0;
        busy_d      = 1'b0;
        if (state_d == StRun) begin
            serial_d    = work_pat_d[idx_d];
            bit_tick_d  = (cnt_d == last_d);
            done_tick_d = (cnt_d == last_d) && (idx_d == IDX_LAST);
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stg_pat_q   <= '0;
            stg_freq_q  <= '0;
            stg_mode_q  <= 1'b0;
            work_pat_q  <= '0;
            work_freq_q <= '0;
            work_mode_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            serial_q    <= 1'b0;
            bit_tick_q  <= 1'b0;
            done_tick_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stg_pat_q   <= stg_pat_d;
            stg_freq_q  <= stg_freq_d;
            stg_mode_q  <= stg_mode_d;
            work_pat_q  <= work_pat_d;
            work_freq_q <= work_freq_d;
            work_mode_q <= work_mode_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            serial_q    <= serial_d;
            bit_tick_q  <= bit_tick_d;
            done_tick_q <= done_tick_d;
            busy_q      <= busy_d;
        end
    end

    assign o_serial_out = serial_q;
    assign o_bit_tick   = bit_tick_q;
    assign o_done_tick  = done_tick_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_diff_freq_serial.sv
// Directed plus randomized bench for diff_freq_serial; expected waveforms are built per bit
// from the pattern, the freq select and the two periods.
module tb_diff_freq_serial;

    localparam int DB   = 16;
    localparam int FAST = 4;
    localparam int SLOW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DB-1:0] i_output_pattern = '0;
    logic [DB-1:0] i_freq_pattern = '0;
    logic          i_mode = 1'b0;
    logic          i_update_tick = 1'b0;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic          o_serial_out;
    logic          o_bit_tick;
    logic          o_done_tick;
    logic          o_busy;

    int checks = 0;
    int failures = 0;

    diff_freq_serial #(
        .DATA_BIT   (DB),
        .FAST_PERIOD(FAST),
        .SLOW_PERIOD(SLOW),
        .CNT_BIT    (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_output_pattern(i_output_pattern),
        .i_freq_pattern  (i_freq_pattern),
        .i_mode          (i_mode),
        .i_update_tick   (i_update_tick),
        .i_start         (i_start),
        .i_stop          (i_stop),
        .o_serial_out    (o_serial_out),
        .o_bit_tick      (o_bit_tick),
        .o_done_tick     (o_done_tick),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"}, o_serial_out, 0);
        chk({tag, "_bit"}, o_bit_tick, 0);
        chk({tag, "_done"}, o_done_tick, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic load(input logic [DB-1:0] pat, input logic [DB-1:0] freq, input logic mode);
        i_output_pattern = pat;
        i_freq_pattern   = freq;
        i_mode           = mode;
        i_update_tick    = 1'b1;
        clk1();
        i_update_tick = 1'b0;
    endtask

    task automatic start();
        i_start = 1'b1;
        clk1();
        i_start = 1'b0;
    endtask

    // Walks one frame cycle by cycle; optional update/start/stop pulses at the first cycle of a bit.
    task automatic run_frame(input string tag, input logic [DB-1:0] pat, input logic [DB-1:0] freq,
                             input bit cont, input int upd_bit, input logic [DB-1:0] upd_pat,
                             input int start_bit, input int stop_bit);
        int ticks;
        ticks = 0;
        for (int b = 0; b < DB; b++) begin
            int p;
            p = freq[b] ? SLOW : FAST;
            for (int c = 0; c < p; c++) begin
                chk({tag, "_out"}, o_serial_out, pat[b]);
                chk({tag, "_bit"}, o_bit_tick, (c == p - 1));
                chk({tag, "_done"}, o_done_tick, (c == p - 1) && (b == DB - 1));
                chk({tag, "_busy"}, o_busy, 1);
                if (o_bit_tick) ticks++;
                if (c == 0 && b == upd_bit) begin
                    i_output_pattern = upd_pat;
                    i_freq_pattern   = '0;
                    i_mode           = 1'b1;
                    i_update_tick    = 1'b1;
                end
                if (c == 0 && b == start_bit) i_start = 1'b1;
                if (c == 0 && b == stop_bit) i_stop = 1'b1;
                clk1();
                i_update_tick = 1'b0;
                i_start       = 1'b0;
                if (i_stop) begin
                    i_stop = 1'b0;
                    chk_idle({tag, "_stopped"});
                    return;
                end
            end
        end
        chk({tag, "_ticks"}, ticks, DB);
        if (!cont) chk_idle({tag, "_after"});
    endtask

    initial begin
        logic [DB-1:0] rp, rf;

        #2;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        clk1();
        chk_idle("post_reset");

        // Plain fast frame.
        load(16'h00A5, 16'h0000, 1'b0);
        chk_idle("staged_only");
        start();
        run_frame("t1", 16'h00A5, 16'h0000, 0, -1, '0, -1, -1);

        // Slow first bit.
        load(16'h0003, 16'h0001, 1'b0);
        start();
        run_frame("t2", 16'h0003, 16'h0001, 0, -1, '0, -1, -1);

        // Continuous: staging change mid-frame shows up only in the next frame, with no gap.
        load(16'h0001, 16'h0000, 1'b1);
        start();
        run_frame("t3f1", 16'h0001, 16'h0000, 1, 8, 16'h8000, -1, -1);
        run_frame("t3f2", 16'h8000, 16'h0000, 1, -1, '0, -1, -1);
        run_frame("t3f3", 16'h8000, 16'h0000, 1, -1, '0, -1, 2);

        // Stop at bit 5, then replay from bit 0.
        load(16'h00A5, 16'h0000, 1'b0);
        start();
        run_frame("t4stop", 16'h00A5, 16'h0000, 0, -1, '0, -1, 5);
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk_idle("t4idle");
        end
        start();
        run_frame("t4replay", 16'h00A5, 16'h0000, 0, -1, '0, -1, -1);

        // Start and stop together in IDLE; then a start pulse during RUN.
        i_start = 1'b1;
        i_stop  = 1'b1;
        clk1();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk_idle("t5both");
        clk1();
        chk_idle("t5both2");
        start();
        run_frame("t5restart", 16'h00A5, 16'h0000, 0, -1, '0, 7, -1);

        // Randomized one-shot frames, update and start in the same cycle.
        for (int n = 0; n < 6; n++) begin
            rp = 16'($urandom);
            rf = 16'($urandom);
            i_output_pattern = rp;
            i_freq_pattern   = rf;
            i_mode           = 1'b0;
            i_update_tick    = 1'b1;
            i_start          = 1'b1;
            clk1();
            i_update_tick = 1'b0;
            i_start       = 1'b0;
            run_frame("rand", rp, rf, 0, -1, '0, -1, -1);
        end

        // Asynchronous reset mid-frame.
        load(16'hFFFF, 16'h0000, 1'b0);
        start();
        for (int i = 0; i < 10; i++) clk1();
        chk("t6pre_busy", o_busy, 1);
        chk("t6pre_out", o_serial_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("t6reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk1();
            chk_idle("t6quiet");
        end
        // Staging was cleared, so a start without update sends an all-zero frame.
        start();
        run_frame("t6zero", 16'h0000, 16'h0000, 0, -1, '0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
